gpioemu_mult_engine: RTL and testbench
======================================

GPIOEMU_MULT_ENGINE -- requirements
Module: gpioemu_mult_engine

Interface
REQ-001 SHALL have parameter OP_W, default 24, operand width in bits (1..32).
REQ-002 SHALL have parameter RES_W, default 32, result window width in bits (1..min(32, 2*OP_W)).
REQ-003 SHALL have parameter CNT_W, default 16, operation counter width in bits (1..32).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port saddress, input, 16, bus register address.
REQ-007 SHALL have port srd, input, 1, read strobe, sampled on clk.
REQ-008 SHALL have port swr, input, 1, write strobe, sampled on clk.
REQ-009 SHALL have port sdata_in, input, 32, write data.
REQ-010 SHALL have port sdata_out, output, 32, registered read data.
REQ-011 SHALL have ports gpio_in (input, 32, GPIO inputs) and gpio_latch (input, 1, capture enable).
REQ-012 SHALL have ports gpio_out (output, 32, zero-extended operation counter) and gpio_in_s_insp (output, 32, captured gpio_in).

Function
REQ-013 Register map SHALL be: 0x037F A1 (RW, low OP_W bits), 0x0388 A2 (RW), 0x0390 W (RO), 0x0398 L (RO), 0x03A0 CS (control/status).
REQ-014 CS read SHALL return {28'b0, ign, done, valid, busy}; CS write bit0=1 SHALL request start, bit3=1 SHALL clear ign.
REQ-015 FSM SHALL have states IDLE, MULT, COUNT, DONE; busy=1 exactly in MULT and COUNT.
REQ-016 Start in IDLE or DONE SHALL snapshot A1, A2 into working copies, clear product, L, done; next state MULT.
REQ-017 Start while busy SHALL be ignored and set sticky ign=1; the running operation SHALL be unaffected.
REQ-018 MULT SHALL last exactly OP_W cycles, step i adding (A1copy << i) to a 2*OP_W-bit product when A2copy[i]=1.
REQ-019 COUNT SHALL last exactly RES_W cycles, step j incrementing L when product[j]=1; L width clog2(RES_W+1), zero-extended on read.
REQ-020 DONE SHALL be entered 1+OP_W+RES_W cycles after the start-write cycle, set done=1, and remain until next start.
REQ-021 valid SHALL equal 1 iff product[2*OP_W-1:RES_W] is all zero (1 when RES_W=2*OP_W), updated on DONE entry.
REQ-022 W read SHALL return product[RES_W-1:0] zero-extended; W and L reads before DONE SHALL return the in-progress values.
REQ-023 Operation counter SHALL increment by 1 on each DONE entry, wrapping modulo 2^CNT_W; gpio_out = zero-extended counter.
REQ-024 A1/A2 writes during busy SHALL update the registers but not the working copies.
REQ-025 Read data SHALL appear on sdata_out the cycle after srd is sampled high and hold until the next read; unmapped addresses SHALL return 0.
REQ-026 srd and swr high together SHALL perform both; read returns the pre-write value.
REQ-027 gpio_in_s SHALL load gpio_in on each clk with gpio_latch=1, else hold; gpio_in_s_insp = gpio_in_s.

Reset
REQ-028 reset=1 SHALL force state IDLE, A1, A2, working copies, product, L, counter, gpio_in_s, sdata_out to 0; busy, done, valid, ign to 0.
REQ-029 reset asserted mid-operation SHALL abort it without incrementing the counter; reset SHALL dominate simultaneous srd/swr.

Verification
REQ-030 Defaults, A1=3, A2=5, start -> DONE after 57 cycles; W=0x0000000F, L=4, CS=0x6, gpio_out=1.
REQ-031 A1=A2=0xFFFFFF, start -> W=0xFE000001, L=8, valid=0, CS=0x4.
REQ-032 Start, second start 10 cycles later -> CS bit3=1, first result unchanged, counter +1 only; write CS=0x8 -> bit3=0.
REQ-033 Start, reset at cycle 20, release -> CS=0, W=0, gpio_out=0; new start completes normally.
REQ-034 CNT_W=2, four complete operations -> gpio_out=0; OP_W=8, RES_W=16, A1=A2=0xFF -> W=0xFE01, L=8, DONE after 25 cycles.
REQ-035 gpio_in=0xA5A5A5A5 with gpio_latch pulse, then gpio_in=0 -> gpio_in_s_insp=0xA5A5A5A5; read 0x1234 -> sdata_out=0.

Source files
------------

// File: rtl/gpioemu_mult_engine_if.sv
// Register bus between a host and the multiplier engine: address, strobes, write and read data.
// The slave returns registered read data one cycle after the read strobe is sampled.
interface gpioemu_mult_engine_if;
   logic [15:0] saddress;
   logic        srd;
   logic        swr;
   logic [31:0] sdata_in;
   logic [31:0] sdata_out;

   modport master (
      output saddress, srd, swr, sdata_in,
      input  sdata_out
   );

   modport slave (
      input  saddress, srd, swr, sdata_in,
      output sdata_out
   );
endinterface

// File: rtl/gpioemu_mult_engine.sv
// Bus-mapped shift-add multiplier with result popcount, operation counter and GPIO capture.
// A start write launches one operation; DONE is reached 1+OP_W+RES_W cycles after the write.
module gpioemu_mult_engine #(
   parameter int OP_W  = 24,
   parameter int RES_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   gpioemu_mult_engine_if.slave bus,
   input  logic [31:0]          gpio_in,
   input  logic                 gpio_latch,
   output logic [31:0]          gpio_out,
   output logic [31:0]          gpio_in_s_insp
);

   localparam int PW = 2 * OP_W;
   localparam int LW = $clog2(RES_W + 1);
   localparam int IW = 6;

   localparam logic [15:0] ADDR_A1 = 16'h037F;
   localparam logic [15:0] ADDR_A2 = 16'h0388;
   localparam logic [15:0] ADDR_W  = 16'h0390;
   localparam logic [15:0] ADDR_L  = 16'h0398;
   localparam logic [15:0] ADDR_CS = 16'h03A0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MULT  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [OP_W-1:0]   a1;
   logic [OP_W-1:0]   a2;
   logic [OP_W-1:0]   a1_copy;
   logic [OP_W-1:0]   a2_copy;
   logic [PW-1:0]     product;
   logic [LW-1:0]     ones_cnt;
   logic [IW-1:0]     idx;
   logic [CNT_W-1:0]  op_cnt;
   logic              ign;
   logic              valid;
   logic              start_q;
   logic [31:0]       gpio_in_s;

   logic              busy;
   logic              done;
   logic              mult_last;
   logic              count_last;

   logic              wr_a1;
   logic              wr_a2;
   logic              wr_cs;
   logic              start_req;
   logic              ign_clr;

   logic [OP_W-1:0]   a2_sh;
   logic [PW-1:0]     prod_sh;
   logic              a2_bit;
   logic              prod_bit;
   logic              upper_zero;
   logic [31:0]       rd_dat;

   assign wr_a1     = bus.swr && (bus.saddress == ADDR_A1);
   assign wr_a2     = bus.swr && (bus.saddress == ADDR_A2);
   assign wr_cs     = bus.swr && (bus.saddress == ADDR_CS);
   assign start_req = wr_cs && bus.sdata_in[0];
   assign ign_clr   = wr_cs && bus.sdata_in[3];

   // Bit i of the multiplier and bit j of the product are picked by shifting, so the
   // step index can stay one fixed width regardless of operand and result widths.
   assign a2_sh      = a2_copy >> idx;
   assign prod_sh    = product >> idx;
   assign a2_bit     = a2_sh[0];
   assign prod_bit   = prod_sh[0];
   assign upper_zero = ((product >> RES_W) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_q)    state_nxt = S_MULT;
         S_MULT:  if (mult_last)  state_nxt = S_COUNT;
         S_COUNT: if (count_last) state_nxt = S_DONE;
         S_DONE:  if (start_q)    state_nxt = S_MULT;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      mult_last  = 1'b0;
      count_last = 1'b0;
      case (state)
         S_MULT: begin
            busy      = 1'b1;
            mult_last = (idx == IW'(OP_W - 1));
         end
         S_COUNT: begin
            busy       = 1'b1;
            count_last = (idx == IW'(RES_W - 1));
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // A start is registered for one cycle before launching, which gives the extra
   // cycle between the start write and the first multiply step.
   always_ff @(posedge clk) begin
      if (reset) begin
         a1        <= '0;
         a2        <= '0;
         a1_copy   <= '0;
         a2_copy   <= '0;
         product   <= '0;
         ones_cnt  <= '0;
         idx       <= '0;
         op_cnt    <= '0;
         ign       <= 1'b0;
         valid     <= 1'b0;
         start_q   <= 1'b0;
         gpio_in_s <= '0;
      end else begin
         if (wr_a1) a1 <= bus.sdata_in[OP_W-1:0];
         if (wr_a2) a2 <= bus.sdata_in[OP_W-1:0];

         start_q <= start_req && !busy;
         if (ign_clr)           ign <= 1'b0;
         if (start_req && busy) ign <= 1'b1;

         if (start_q) begin
            a1_copy  <= a1;
            a2_copy  <= a2;
            product  <= '0;
            ones_cnt <= '0;
            idx      <= '0;
         end else if (state == S_MULT) begin
            if (a2_bit) product <= product + (PW'(a1_copy) << idx);
            idx <= mult_last ? '0 : idx + IW'(1);
         end else if (state == S_COUNT) begin
            ones_cnt <= ones_cnt + LW'(prod_bit);
            idx      <= count_last ? '0 : idx + IW'(1);
            if (count_last) begin
               valid  <= upper_zero;
               op_cnt <= op_cnt + CNT_W'(1);
            end
         end

         if (gpio_latch) gpio_in_s <= gpio_in;
      end
   end

   always_comb begin
      rd_dat = '0;
      case (bus.saddress)
         ADDR_A1: rd_dat = 32'(a1);
         ADDR_A2: rd_dat = 32'(a2);
         ADDR_W:  rd_dat = 32'(product[RES_W-1:0]);
         ADDR_L:  rd_dat = 32'(ones_cnt);
         ADDR_CS: rd_dat = {28'b0, ign, done, valid, busy};
         default: rd_dat = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.sdata_out <= '0;
      end else if (bus.srd) begin
         bus.sdata_out <= rd_dat;
      end
   end

   assign gpio_out       = 32'(op_cnt);
   assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpioemu_mult_engine.sv
// Randomised bench for the multiplier engine: a default-parameter instance and a small
// instance (OP_W=8, RES_W=16, CNT_W=2) are checked against an arithmetic reference model.
module tb_gpioemu_mult_engine;

   localparam logic [15:0] A_A1 = 16'h037F;
   localparam logic [15:0] A_A2 = 16'h0388;
   localparam logic [15:0] A_W  = 16'h0390;
   localparam logic [15:0] A_L  = 16'h0398;
   localparam logic [15:0] A_CS = 16'h03A0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] gin = '0;
   logic        glat = 1'b0;
   logic [31:0] gout0, gout1, ins0, ins1;

   int checks = 0;
   int errors = 0;
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;

   always #5 clk = ~clk;

   gpioemu_mult_engine_if b0 ();
   gpioemu_mult_engine_if b1 ();

   gpioemu_mult_engine dut0 (
      .clk(clk), .reset(reset), .bus(b0),
      .gpio_in(gin), .gpio_latch(glat),
      .gpio_out(gout0), .gpio_in_s_insp(ins0)
   );

   gpioemu_mult_engine #(.OP_W(8), .RES_W(16), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .bus(b1),
      .gpio_in(gin), .gpio_latch(glat),
      .gpio_out(gout1), .gpio_in_s_insp(ins1)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int sel, input logic [15:0] a, input logic rd, input logic wr,
                      input logic [31:0] d);
      if (sel == 0) begin
         b0.saddress = a; b0.srd = rd; b0.swr = wr; b0.sdata_in = d;
      end else begin
         b1.saddress = a; b1.srd = rd; b1.swr = wr; b1.sdata_in = d;
      end
   endtask

   task automatic bus_wr(input int sel, input logic [15:0] a, input logic [31:0] d);
      drv(sel, a, 1'b0, 1'b1, d);
      cyc;
      drv(sel, 16'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic bus_rd(input int sel, input logic [15:0] a, output logic [31:0] d);
      drv(sel, a, 1'b1, 1'b0, 32'h0);
      cyc;
      d = (sel == 0) ? b0.sdata_out : b1.sdata_out;
      drv(sel, 16'h0, 1'b0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] gpo(input int sel);
      return (sel == 0) ? gout0 : gout1;
   endfunction

   // Reference: full-width product, low RES_W bits as W, popcount of W, overflow check.
   task automatic model(input int opw, input int resw, input logic [31:0] a1, input logic [31:0] a2,
                        output logic [31:0] w, output logic [31:0] l, output logic v);
      logic [63:0] m, p, wm;
      m  = (64'd1 << opw) - 64'd1;
      p  = ({32'b0, a1} & m) * ({32'b0, a2} & m);
      wm = (64'd1 << resw) - 64'd1;
      w  = 32'(p & wm);
      l  = 32'($countones(w));
      v  = ((p >> resw) == 64'd0);
   endtask

   // Loads operands, starts, and counts cycles from the start-write edge to the counter step.
   task automatic run_op(input int sel, input logic [31:0] a1, input logic [31:0] a2, output int lat);
      logic [31:0] old;
      bus_wr(sel, A_A1, a1);
      bus_wr(sel, A_A2, a2);
      old = gpo(sel);
      bus_wr(sel, A_CS, 32'h1);
      lat = 0;
      while (gpo(sel) == old && lat < 300) begin
         cyc;
         lat++;
      end
      if (sel == 0) exp_cnt0 = (exp_cnt0 + 1) % 65536;
      else          exp_cnt1 = (exp_cnt1 + 1) % 4;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      drv(0, 16'h0, 1'b0, 1'b0, 32'h0);
      drv(1, 16'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      repeat (3) cyc;
      reset = 1'b0;
      checks++; if (b0.sdata_out !== 32'h0) begin errors++; $display("FAIL reset_sdata_out got %h want %h", b0.sdata_out, 32'h0); end
      checks++; if (gout0 !== 32'h0) begin errors++; $display("FAIL reset_gpio_out got %h want %h", gout0, 32'h0); end
      checks++; if (ins0 !== 32'h0) begin errors++; $display("FAIL reset_insp got %h want %h", ins0, 32'h0); end
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_cs got %h want %h", r, 32'h0); end
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_w got %h want %h", r, 32'h0); end
      bus_rd(0, A_A1, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_a1 got %h want %h", r, 32'h0); end
      exp_cnt0 = 0;
      exp_cnt1 = 0;
   endtask

   task automatic test_basic;
      logic [31:0] r;
      int lat;
      run_op(0, 32'd3, 32'd5, lat);
      checks++; if (lat !== 57) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, 57); end
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL basic_w got %h want %h", r, 32'hF); end
      bus_rd(0, A_L, r);
      checks++; if (r !== 32'd4) begin errors++; $display("FAIL basic_l got %h want %h", r, 32'd4); end
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'h6) begin errors++; $display("FAIL basic_cs got %h want %h", r, 32'h6); end
      checks++; if (gout0 !== 32'd1) begin errors++; $display("FAIL basic_gpio_out got %h want %h", gout0, 32'd1); end
   endtask

   task automatic test_max;
      logic [31:0] r;
      int lat;
      run_op(0, 32'hFFFFFF, 32'hFFFFFF, lat);
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'hFE000001) begin errors++; $display("FAIL max_w got %h want %h", r, 32'hFE000001); end
      bus_rd(0, A_L, r);
      checks++; if (r !== 32'd8) begin errors++; $display("FAIL max_l got %h want %h", r, 32'd8); end
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'h4) begin errors++; $display("FAIL max_cs got %h want %h", r, 32'h4); end
   endtask

   task automatic test_random;
      logic [31:0] a1, a2, w, l, r;
      logic v;
      int lat;
      for (int i = 0; i < 8; i++) begin
         a1 = $urandom & ((32'd1 << $urandom_range(1, 24)) - 32'd1);
         a2 = $urandom & ((32'd1 << $urandom_range(1, 24)) - 32'd1);
         model(24, 32, a1, a2, w, l, v);
         run_op(0, a1, a2, lat);
         checks++; if (lat !== 57) begin errors++; $display("FAIL rand_latency got %0d want %0d", lat, 57); end
         bus_rd(0, A_W, r);
         checks++; if (r !== w) begin errors++; $display("FAIL rand_w a1=%h a2=%h got %h want %h", a1, a2, r, w); end
         bus_rd(0, A_L, r);
         checks++; if (r !== l) begin errors++; $display("FAIL rand_l got %h want %h", r, l); end
         bus_rd(0, A_CS, r);
         checks++; if (r !== (32'h4 | {30'b0, v, 1'b0})) begin errors++; $display("FAIL rand_cs got %h want %h", r, 32'h4 | {30'b0, v, 1'b0}); end
         bus_rd(0, A_A2, r);
         checks++; if (r !== a2) begin errors++; $display("FAIL rand_a2_readback got %h want %h", r, a2); end
         checks++; if (gout0 !== 32'(exp_cnt0)) begin errors++; $display("FAIL rand_gpio_out got %h want %h", gout0, exp_cnt0); end
      end
   endtask

   task automatic test_busy_start;
      logic [31:0] r, old;
      int n;
      bus_wr(0, A_A1, 32'd7);
      bus_wr(0, A_A2, 32'd9);
      old = gout0;
      bus_wr(0, A_CS, 32'h1);
      repeat (10) cyc;
      bus_rd(0, A_CS, r);
      checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL busy_bit got %b want %b", r[0], 1'b1); end
      bus_wr(0, A_A1, 32'd100);
      bus_wr(0, A_CS, 32'h1);
      n = 0;
      while (gout0 == old && n < 300) begin cyc; n++; end
      exp_cnt0 = (exp_cnt0 + 1) % 65536;
      repeat (80) cyc;
      checks++; if (gout0 !== 32'(exp_cnt0)) begin errors++; $display("FAIL busy_counter got %h want %h", gout0, exp_cnt0); end
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'd63) begin errors++; $display("FAIL busy_w got %h want %h", r, 32'd63); end
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'hE) begin errors++; $display("FAIL busy_cs_ign got %h want %h", r, 32'hE); end
      bus_rd(0, A_A1, r);
      checks++; if (r !== 32'd100) begin errors++; $display("FAIL busy_a1_write got %h want %h", r, 32'd100); end
      bus_wr(0, A_CS, 32'h8);
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'h6) begin errors++; $display("FAIL ign_clear got %h want %h", r, 32'h6); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r;
      int lat;
      bus_wr(0, A_A1, 32'd3);
      bus_wr(0, A_A2, 32'd5);
      bus_wr(0, A_CS, 32'h1);
      repeat (20) cyc;
      drv(0, A_A1, 1'b1, 1'b1, 32'h55);
      reset = 1'b1;
      cyc;
      checks++; if (b0.sdata_out !== 32'h0) begin errors++; $display("FAIL reset_dominates_rd got %h want %h", b0.sdata_out, 32'h0); end
      drv(0, 16'h0, 1'b0, 1'b0, 32'h0);
      cyc;
      reset = 1'b0;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      bus_rd(0, A_CS, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL abort_cs got %h want %h", r, 32'h0); end
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL abort_w got %h want %h", r, 32'h0); end
      bus_rd(0, A_A1, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_dominates_wr got %h want %h", r, 32'h0); end
      checks++; if (gout0 !== 32'h0) begin errors++; $display("FAIL abort_gpio_out got %h want %h", gout0, 32'h0); end
      run_op(0, 32'd3, 32'd5, lat);
      checks++; if (lat !== 57) begin errors++; $display("FAIL restart_latency got %0d want %0d", lat, 57); end
      bus_rd(0, A_W, r);
      checks++; if (r !== 32'hF) begin errors++; $display("FAIL restart_w got %h want %h", r, 32'hF); end
      checks++; if (gout0 !== 32'd1) begin errors++; $display("FAIL restart_gpio_out got %h want %h", gout0, 32'd1); end
   endtask

   task automatic test_small;
      logic [31:0] a1, a2, w, l, r;
      logic v;
      int lat;
      for (int i = 0; i < 3; i++) begin
         a1 = $urandom_range(0, 255);
         a2 = $urandom_range(0, 255);
         model(8, 16, a1, a2, w, l, v);
         run_op(1, a1, a2, lat);
         bus_rd(1, A_W, r);
         checks++; if (r !== w) begin errors++; $display("FAIL small_w got %h want %h", r, w); end
         bus_rd(1, A_L, r);
         checks++; if (r !== l) begin errors++; $display("FAIL small_l got %h want %h", r, l); end
         checks++; if (gout1 !== 32'(exp_cnt1)) begin errors++; $display("FAIL small_counter got %h want %h", gout1, exp_cnt1); end
      end
      run_op(1, 32'hFF, 32'hFF, lat);
      checks++; if (lat !== 25) begin errors++; $display("FAIL small_latency got %0d want %0d", lat, 25); end
      bus_rd(1, A_W, r);
      checks++; if (r !== 32'hFE01) begin errors++; $display("FAIL small_ff_w got %h want %h", r, 32'hFE01); end
      bus_rd(1, A_L, r);
      checks++; if (r !== 32'd8) begin errors++; $display("FAIL small_ff_l got %h want %h", r, 32'd8); end
      bus_rd(1, A_CS, r);
      checks++; if (r !== 32'h6) begin errors++; $display("FAIL small_ff_cs got %h want %h", r, 32'h6); end
      checks++; if (gout1 !== 32'h0) begin errors++; $display("FAIL small_wrap got %h want %h", gout1, 32'h0); end
   endtask

   task automatic test_gpio;
      gin = 32'hA5A5A5A5;
      glat = 1'b1;
      cyc;
      glat = 1'b0;
      gin = 32'h0;
      cyc;
      checks++; if (ins0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL gpio_capture got %h want %h", ins0, 32'hA5A5A5A5); end
      gin = $urandom;
      repeat (3) cyc;
      checks++; if (ins1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL gpio_hold got %h want %h", ins1, 32'hA5A5A5A5); end
   endtask

   task automatic test_bus_edges;
      logic [31:0] r, prev, nv;
      bus_rd(0, 16'h1234, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_rd got %h want %h", r, 32'h0); end
      bus_rd(0, A_A1, prev);
      nv = $urandom & 32'hFFFFFF;
      drv(0, A_A1, 1'b1, 1'b1, nv);
      cyc;
      r = b0.sdata_out;
      drv(0, 16'h0, 1'b0, 1'b0, 32'h0);
      checks++; if (r !== prev) begin errors++; $display("FAIL rdwr_pre_value got %h want %h", r, prev); end
      repeat (2) cyc;
      checks++; if (b0.sdata_out !== prev) begin errors++; $display("FAIL rd_hold got %h want %h", b0.sdata_out, prev); end
      bus_rd(0, A_A1, r);
      checks++; if (r !== nv) begin errors++; $display("FAIL rdwr_post_value got %h want %h", r, nv); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_max;
      test_random;
      test_busy_start;
      test_reset_mid;
      test_small;
      test_gpio;
      test_bus_edges;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
